// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
//   Shares a single memory port between an instruction-fetch port and a
//   load/store data port. Only one transfer is in flight at a time. A
//   watchdog aborts any transfer that stalls for MAX_WAIT cycles.
//
// Handshake: a port raises its request (instr_read, or data_read/data_write)
//   and holds it, together with its address and write data, until its valid
//   output pulses for one cycle. The memory side sees mem_read/mem_write held
//   with a stable address and write data. The transfer completes on the first
//   rising edge where mem_waitrequest is 0.
//
// Parameters
//   ARB_MODE  0 = round-robin, 1 = data port always wins
//   MAX_WAIT  wait cycles tolerated per transfer before abort (1..65535)
//
// Ports
//   clk, reset                      clock, async active-low reset
//   instr_address/read              fetch request
//   instr_readdata/valid            fetch result and completion pulse
//   data_address/read/write/writedata  load/store request
//   data_readdata/valid             load result and completion pulse
//   mem_address/read/write/writedata   shared memory request
//   mem_readdata/waitrequest        shared memory response and stall
//   timeout_err                     sticky watchdog flag
// ---------------------------------------------------------------------------
module mips_mem_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  input  logic        instr_read,
  output logic [31:0] instr_readdata,
  output logic        instr_valid,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_valid,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic        r_last_data;

  logic        w_instr_elig;
  logic        w_data_elig;
  logic        w_grant_data;
  logic        w_abort;
  logic [31:0] w_rd_word;

  // A port whose valid is high this cycle is still holding its old request;
  // masking it stops that request from being granted a second time.
  assign w_instr_elig = instr_read & ~instr_valid;
  assign w_data_elig  = (data_read | data_write) & ~data_valid;

  always_comb begin
    w_grant_data = 1'b0;
    if (w_data_elig && !w_instr_elig) begin
      w_grant_data = 1'b1;
    end else if (w_data_elig && w_instr_elig) begin
      w_grant_data = (ARB_MODE == 1) ? 1'b1 : ~r_last_data;
    end
  end

  // The counter holds the number of wait cycles already seen, so the stall
  // that would make it reach MAX_WAIT is the one that aborts.
  assign w_abort   = mem_waitrequest && (r_wait_cnt == WAIT_LAST);
  assign w_rd_word = w_abort ? 32'hFFFF_FFFF : mem_readdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_wait_cnt     <= 16'd0;
      r_last_data    <= 1'b1;
      instr_readdata <= 32'd0;
      instr_valid    <= 1'b0;
      data_readdata  <= 32'd0;
      data_valid     <= 1'b0;
      mem_address    <= 32'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= 32'd0;
      timeout_err    <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_instr_elig || w_data_elig) begin
            r_wait_cnt  <= 16'd0;
            r_last_data <= w_grant_data;
            if (w_grant_data) begin
              r_state     <= ST_DATA;
              mem_address <= data_address;
              // read and write together is a store
              mem_read    <= ~data_write;
              mem_write   <= data_write;
              if (data_write) mem_writedata <= data_writedata;
            end else begin
              r_state     <= ST_INSTR;
              mem_address <= instr_address;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
            end
          end
        end
        ST_INSTR, ST_DATA: begin
          if (!mem_waitrequest || w_abort) begin
            r_state   <= ST_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (w_abort) timeout_err <= 1'b1;
            if (r_state == ST_INSTR) begin
              instr_valid    <= 1'b1;
              instr_readdata <= w_rd_word;
            end else begin
              data_valid <= 1'b1;
              if (mem_read) data_readdata <= w_rd_word;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- ARB_MODE, default 0: 0 = round-robin, 1 = data port always wins.
- MAX_WAIT, default 255: maximum mem_waitrequest cycles per transaction before abort; range 1..65535.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_address  in  32  fetch address.
- instr_read  in  1  fetch request, held until instr_valid.
- instr_readdata  out  32  fetched word.
- instr_valid  out  1  one-cycle fetch completion pulse.
- data_address  in  32  load/store address.
- data_read  in  1  load request, held until data_valid.
- data_write  in  1  store request, held until data_valid.
- data_writedata  in  32  store data.
- data_readdata  out  32  loaded word.
- data_valid  out  1  one-cycle load/store completion pulse.
- mem_address  out  32  shared memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_writedata  out  32  memory write data.
- mem_readdata  in  32  memory read data.
- mem_waitrequest  in  1  memory stall; transfer completes in a cycle where it is 0.
- timeout_err  out  1  sticky watchdog flag.

Function
REQ-003 The block SHALL implement three states: IDLE, INSTR, DATA.
REQ-004 IDLE behaviour:
- mem_read and mem_write SHALL be 0.
- A request SHALL be eligible if asserted and its own valid output is not high this cycle. This masks the held request in the pulse cycle.
REQ-005 Grant rules in IDLE:
- ARB_MODE=1: an eligible data request SHALL win over an eligible fetch.
- ARB_MODE=0: with both eligible, the port not granted last SHALL win; a lone eligible request SHALL win.
REQ-006 On a grant edge the block SHALL register address (and write data for stores) onto the mem_* outputs and enter INSTR or DATA; mem_read (fetch/load) or mem_write (store) SHALL be high from the next cycle.
REQ-007 data_read and data_write both high SHALL be treated as a store: mem_read=0, and data_readdata SHALL be unchanged on completion.
REQ-008 In INSTR/DATA, mem_address, mem_writedata and the strobes SHALL hold stable while mem_waitrequest=1.
REQ-009 Completion, on an edge where mem_waitrequest=0 in INSTR/DATA:
- The block SHALL return to IDLE and drop the strobes.
- For reads, it SHALL register mem_readdata into the port's readdata.
- The port's valid SHALL be high for exactly the following cycle.
REQ-010 Minimum latency SHALL be request sampled at edge 0, strobe during cycle 1, valid during cycle 2; sustained throughput SHALL be one transfer per two cycles.
REQ-011 Readdata outputs SHALL hold their last value until the next completed read on that port.
REQ-012 Watchdog operation:
- A wait counter SHALL clear on entry to INSTR/DATA.
- It SHALL increment each cycle with mem_waitrequest=1.
REQ-013 Watchdog abort: on reaching MAX_WAIT with mem_waitrequest still 1, the block SHALL:
- abort to IDLE and drop the strobes;
- pulse the port's valid with readdata = 32'hFFFFFFFF for reads (stores: readdata unchanged);
- set timeout_err.
REQ-014 timeout_err SHALL stay set until reset.
REQ-015 The last-grant record SHALL update on every grant and SHALL NOT update on completion.
REQ-016 A request dropped before its valid SHALL NOT cancel a transaction already granted; the transaction completes and its valid still pulses.

Reset
REQ-017 While reset=0 the block SHALL immediately clear all outputs to 0, state to IDLE, wait counter to 0, timeout_err to 0, and last-grant to "data" so the first round-robin contest goes to fetch.
REQ-018 Reset asserted mid-transaction SHALL drop mem_read/mem_write asynchronously; no valid SHALL pulse for the aborted transfer.
REQ-019 The first grant SHALL occur no earlier than the first rising edge after reset returns to 1.

Verification
REQ-020 Fetch only: instr_read=1, instr_address=32'h00000010, waitrequest=0, mem_readdata=32'h2403_0F0F -> mem_read high with mem_address=32'h10 in cycle 1; instr_valid in cycle 2 with instr_readdata=32'h24030F0F; no regrant in cycle 2.
REQ-021 Contention, ARB_MODE=0, both requests held continuously from reset -> grants alternate fetch, data, fetch, data; each valid pulses once per grant.
REQ-022 Contention, ARB_MODE=1 -> data granted first; fetch granted only in an IDLE cycle with no eligible data request.
REQ-023 Store with waitrequest=1 for 3 cycles, data_writedata=32'h00000FFF -> mem_write, mem_address and mem_writedata stable for 4 cycles; data_valid in the cycle after waitrequest falls; data_readdata unchanged.
REQ-024 MAX_WAIT=4, waitrequest stuck at 1 on a load -> abort after 4 wait cycles; data_valid with data_readdata=32'hFFFFFFFF; timeout_err=1 until reset.
REQ-025 reset=0 during a stalled fetch -> mem_read=0 and all outputs 0 without a clock edge; no instr_valid; after release, the fetch is regranted if still requested.
